// File: rtl/nnlut_pkg.sv
// nnlut_pkg: shared widths, evaluator latency and the requantize/saturate
// helper used by the NN-LUT receive path.
package nnlut_pkg;

    localparam int RES_WIDTH_D = 41;
    localparam int OUT_WIDTH_D = 8;
    localparam int EVAL_LAT    = 2;

    // Wide enough for any RES_WIDTH+1 sum without overflow.
    localparam int CALC_W = 64;

    // Round-half-up arithmetic shift, then clamp to a signed ow-bit range.
    function automatic logic signed [CALC_W-1:0] requant(
        input logic signed [CALC_W-1:0] v,
        input int                       shift,
        input int                       ow
    );
        logic signed [CALC_W-1:0] t;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        t  = (v + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (t > hi) begin
            requant = hi;
        end else if (t < lo) begin
            requant = lo;
        end else begin
            requant = t;
        end
    endfunction

endpackage

// File: rtl/nnlut_rx_fifo.sv
// nnlut_rx_fifo: DEPTH x WIDTH first-word-fall-through FIFO.
// Ports: push/wdata in, pop in, rdata (head), count, full, empty out.
module nnlut_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk_p,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr;
    logic             rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd    = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr    = push && (!full || rd);
    assign rdata = mem[rptr];

    always_ff @(posedge clk_p) begin
        if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (rd) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/nnlut_rx.sv
// nnlut_rx: captures evaluator results, requantizes, buffers, grants credit.
// Ports: x_issue_n/res_valid_n/res_data in; issue_ok, out_valid_n/out_data
// with out_ready; sticky err_ovf/err_unexp cleared by err_clr.
module nnlut_rx
    import nnlut_pkg::*;
#(
    parameter int RES_WIDTH = RES_WIDTH_D,
    parameter int OUT_WIDTH = OUT_WIDTH_D,
    parameter int SHIFT     = 8,
    parameter int DEPTH     = 8
) (
    input  logic                        clk_p,
    input  logic                        rst_n,
    input  logic                        x_issue_n,
    input  logic                        res_valid_n,
    input  logic signed [RES_WIDTH-1:0] res_data,
    output logic                        issue_ok,
    output logic                        out_valid_n,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        err_ovf,
    output logic                        err_unexp,
    input  logic                        err_clr
);

    localparam int CW = $clog2(DEPTH + 1);

    logic signed [CALC_W-1:0] res_ext;
    logic [OUT_WIDTH-1:0]     q_d;
    logic [OUT_WIDTH-1:0]     stg_q;
    logic                     stg_v;
    logic [OUT_WIDTH-1:0]     fifo_head;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    logic                     push;
    logic                     ovf_ev;
    logic                     unexp_ev;
    logic                     inc;
    logic                     dec;
    logic [CW-1:0]            infl;
    logic [CW-1:0]            infl_d;
    logic [CW:0]              occ;

    assign res_ext = {{(CALC_W-RES_WIDTH){res_data[RES_WIDTH-1]}}, res_data};
    assign q_d     = OUT_WIDTH'(requant(res_ext, SHIFT, OUT_WIDTH));

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            stg_v <= 1'b0;
            stg_q <= '0;
        end else begin
            stg_v <= !res_valid_n;
            if (!res_valid_n) begin
                stg_q <= q_d;
            end
        end
    end

    assign pop    = !fifo_empty && out_ready;
    assign push   = stg_v && (!fifo_full || pop);
    assign ovf_ev = stg_v && fifo_full && !pop;

    nnlut_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .push  (push),
        .wdata (stg_q),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inc = !x_issue_n;
    assign dec = !res_valid_n;

    always_comb begin
        infl_d   = infl;
        unexp_ev = dec && (infl == '0);
        unique case (1'b1)
            inc && !dec: begin
                if (infl != CW'(DEPTH)) begin
                    infl_d = infl + 1'b1;
                end
            end
            dec && !inc: begin
                if (infl != '0) begin
                    infl_d = infl - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            infl      <= '0;
            err_ovf   <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            infl      <= infl_d;
            err_ovf   <= ovf_ev | (err_ovf & ~err_clr);
            err_unexp <= unexp_ev | (err_unexp & ~err_clr);
        end
    end

    // Every issued x reserves a slot until it leaves the FIFO, so a
    // result can always be absorbed. Pops are credited one edge late.
    assign occ = {1'b0, infl} + {{CW{1'b0}}, stg_v} + {1'b0, fifo_count};
    assign issue_ok = (occ < (CW + 1)'(DEPTH));

    assign out_valid_n = fifo_empty;
    assign out_data    = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_nnlut_rx.sv
// tb_nnlut_rx: directed self-checking bench for nnlut_rx.
// Inputs change and outputs are sampled on the falling edge.
module tb_nnlut_rx;

    localparam int DEPTH = 8;

    logic              clk_p       = 1'b0;
    logic              rst_n       = 1'b0;
    logic              x_issue_n   = 1'b1;
    logic              res_valid_n = 1'b1;
    logic signed [40:0] res_data   = '0;
    logic              out_ready   = 1'b0;
    logic              err_clr     = 1'b0;
    logic              issue_ok;
    logic              out_valid_n;
    logic signed [7:0] out_data;
    logic              err_ovf;
    logic              err_unexp;

    int n_pass  = 0;
    int n_total = 0;

    nnlut_rx dut (
        .clk_p       (clk_p),
        .rst_n       (rst_n),
        .x_issue_n   (x_issue_n),
        .res_valid_n (res_valid_n),
        .res_data    (res_data),
        .issue_ok    (issue_ok),
        .out_valid_n (out_valid_n),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .err_ovf     (err_ovf),
        .err_unexp   (err_unexp),
        .err_clr     (err_clr)
    );

    always #5 clk_p = ~clk_p;

    task automatic tick();
        @(negedge clk_p);
    endtask

    task automatic send(input int v);
        res_valid_n = 1'b0;
        res_data    = 41'(v);
        tick();
        res_valid_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if (out_valid_n !== 1'b1) $display("FAIL rst_valid got %b want 1", out_valid_n);
        else n_pass++;
        n_total++;
        if (out_data !== 8'sd0) $display("FAIL rst_data got %0d want 0", out_data);
        else n_pass++;
        n_total++;
        if (issue_ok !== 1'b1) $display("FAIL rst_issue_ok got %b want 1", issue_ok);
        else n_pass++;
        n_total++;
        if ({err_ovf, err_unexp} !== 2'b00)
            $display("FAIL rst_err got %b want 00", {err_ovf, err_unexp});
        else n_pass++;
        @(negedge clk_p);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_requant_order();
        int exp_q [4] = '{2, -1, 0, 0};
        out_ready = 1'b0;
        send(384);
        n_total++;
        if (out_valid_n !== 1'b1) $display("FAIL lat_early got %b want 1", out_valid_n);
        else n_pass++;
        send(-384);
        n_total++;
        if (out_valid_n !== 1'b0 || out_data !== 8'sd2)
            $display("FAIL lat_first got v=%b d=%0d want v=0 d=2", out_valid_n, out_data);
        else n_pass++;
        send(127);
        send(0);
        tick();
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (out_valid_n !== 1'b0 || out_data !== 8'(exp_q[i]))
                $display("FAIL order[%0d] got v=%b d=%0d want v=0 d=%0d",
                         i, out_valid_n, out_data, exp_q[i]);
            else n_pass++;
            tick();
        end
        n_total++;
        if (out_valid_n !== 1'b1) $display("FAIL order_empty got %b want 1", out_valid_n);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        int vals [4]  = '{40000, -40000, 32639, 32640};
        int exp_q [4] = '{127, -128, 127, 127};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                res_valid_n = 1'b0;
                res_data    = 41'(vals[i]);
            end else begin
                res_valid_n = 1'b1;
            end
            tick();
            if (i >= 1) begin
                n_total++;
                if (out_valid_n !== 1'b0 || out_data !== 8'(exp_q[i-1]))
                    $display("FAIL sat[%0d] got v=%b d=%0d want v=0 d=%0d",
                             i - 1, out_valid_n, out_data, exp_q[i-1]);
                else n_pass++;
            end
        end
        res_valid_n = 1'b1;
        tick();
        n_total++;
        if (out_valid_n !== 1'b1) $display("FAIL sat_empty got %b want 1", out_valid_n);
        else n_pass++;
        out_ready = 1'b0;
        err_clr   = 1'b1;
        tick();
        err_clr   = 1'b0;
        n_total++;
        if ({err_ovf, err_unexp} !== 2'b00)
            $display("FAIL clr_all got %b want 00", {err_ovf, err_unexp});
        else n_pass++;
    endtask

    task automatic test_credit();
        bit hist [64];
        int issues = 0;
        int rets   = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 24; k++) begin
            hist[k]   = issue_ok;
            x_issue_n = !issue_ok;
            if (issue_ok) issues++;
            if (k >= 2 && hist[k-2]) begin
                rets++;
                res_valid_n = 1'b0;
                res_data    = 41'(rets * 256);
            end else begin
                res_valid_n = 1'b1;
            end
            tick();
        end
        x_issue_n   = 1'b1;
        res_valid_n = 1'b1;
        n_total++;
        if (issues != DEPTH) $display("FAIL credit_issues got %0d want %0d", issues, DEPTH);
        else n_pass++;
        n_total++;
        if (issue_ok !== 1'b0) $display("FAIL credit_full got %b want 0", issue_ok);
        else n_pass++;
        n_total++;
        if ({err_ovf, err_unexp} !== 2'b00)
            $display("FAIL credit_err got %b want 00", {err_ovf, err_unexp});
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_total++;
            if (out_valid_n !== 1'b0 || out_data !== 8'(i))
                $display("FAIL credit_drain[%0d] got v=%b d=%0d want v=0 d=%0d",
                         i, out_valid_n, out_data, i);
            else n_pass++;
            tick();
        end
        out_ready = 1'b0;
        n_total++;
        if (issue_ok !== 1'b1 || out_valid_n !== 1'b1)
            $display("FAIL credit_after got ok=%b v=%b want ok=1 v=1", issue_ok, out_valid_n);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send(i * 256);
        out_ready = 1'b1;
        n_total++;
        if (out_valid_n !== 1'b0 || out_data !== 8'sd1)
            $display("FAIL simul_head got v=%b d=%0d want v=0 d=1", out_valid_n, out_data);
        else n_pass++;
        tick();
        n_total++;
        if (issue_ok !== 1'b0 || err_ovf !== 1'b0)
            $display("FAIL simul_count got ok=%b ovf=%b want ok=0 ovf=0", issue_ok, err_ovf);
        else n_pass++;
        for (int i = 2; i <= DEPTH + 1; i++) begin
            n_total++;
            if (out_valid_n !== 1'b0 || out_data !== 8'(i))
                $display("FAIL simul_drain[%0d] got v=%b d=%0d want v=0 d=%0d",
                         i, out_valid_n, out_data, i);
            else n_pass++;
            tick();
        end
        n_total++;
        if (out_valid_n !== 1'b1) $display("FAIL simul_empty got %b want 1", out_valid_n);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send(i * 256);
        n_total++;
        if (err_ovf !== 1'b0) $display("FAIL ovf_early got %b want 0", err_ovf);
        else n_pass++;
        send((DEPTH + 2) * 256);
        n_total++;
        if (err_ovf !== 1'b1) $display("FAIL ovf_set got %b want 1", err_ovf);
        else n_pass++;
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_total++;
            if (out_data !== 8'(i))
                $display("FAIL ovf_drain[%0d] got %0d want %0d", i, out_data, i);
            else n_pass++;
            tick();
        end
        out_ready = 1'b0;
        n_total++;
        if (out_valid_n !== 1'b1) $display("FAIL ovf_empty got %b want 1", out_valid_n);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_total++;
        if ({err_ovf, err_unexp} !== 2'b00)
            $display("FAIL ovf_clr got %b want 00", {err_ovf, err_unexp});
        else n_pass++;
    endtask

    task automatic test_unexpected();
        out_ready = 1'b0;
        send(5 * 256);
        n_total++;
        if (err_unexp !== 1'b1) $display("FAIL unexp_set got %b want 1", err_unexp);
        else n_pass++;
        err_clr     = 1'b1;
        res_valid_n = 1'b0;
        res_data    = 41'(6 * 256);
        tick();
        res_valid_n = 1'b1;
        n_total++;
        if (err_unexp !== 1'b1 || out_data !== 8'sd5)
            $display("FAIL unexp_win got e=%b d=%0d want e=1 d=5", err_unexp, out_data);
        else n_pass++;
        tick();
        err_clr = 1'b0;
        n_total++;
        if (err_unexp !== 1'b0) $display("FAIL unexp_clr got %b want 0", err_unexp);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 5; i <= 6; i++) begin
            n_total++;
            if (out_valid_n !== 1'b0 || out_data !== 8'(i))
                $display("FAIL unexp_out[%0d] got v=%b d=%0d want v=0 d=%0d",
                         i, out_valid_n, out_data, i);
            else n_pass++;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(i * 256);
        x_issue_n = 1'b0;
        tick();
        tick();
        x_issue_n = 1'b1;
        tick();
        n_total++;
        if (issue_ok !== 1'b1 || out_valid_n !== 1'b0 || err_unexp !== 1'b1)
            $display("FAIL mid_pre got ok=%b v=%b e=%b want ok=1 v=0 e=1",
                     issue_ok, out_valid_n, err_unexp);
        else n_pass++;
        x_issue_n = 1'b0;
        tick();
        x_issue_n = 1'b1;
        n_total++;
        if (issue_ok !== 1'b0) $display("FAIL mid_full got %b want 0", issue_ok);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid_n !== 1'b1 || out_data !== 8'sd0 || issue_ok !== 1'b1 ||
            err_ovf !== 1'b0 || err_unexp !== 1'b0)
            $display("FAIL mid_rst got v=%b d=%0d ok=%b ovf=%b un=%b want 1 0 1 0 0",
                     out_valid_n, out_data, issue_ok, err_ovf, err_unexp);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (issue_ok !== 1'b1 || out_valid_n !== 1'b1)
            $display("FAIL mid_release got ok=%b v=%b want ok=1 v=1", issue_ok, out_valid_n);
        else n_pass++;
        send(3 * 256);
        n_total++;
        if (err_unexp !== 1'b1) $display("FAIL mid_unexp got %b want 1", err_unexp);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid_n !== 1'b0 || out_data !== 8'sd3)
            $display("FAIL mid_out got v=%b d=%0d want v=0 d=3", out_valid_n, out_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_requant_order();
        test_saturation();
        test_credit();
        test_simultaneous();
        test_overflow();
        test_unexpected();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
